// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared constants and owner encoding for the bullet slot allocator
package bullet_pkg;

    localparam int          DEF_NUM_SLOTS = 30;
    localparam int          DEF_NUM_REQ   = 2;
    localparam int unsigned DEF_COOLDOWN  = 5000000;
    localparam int          DEF_SLOT_W    = 5;
    localparam int          DEF_OWN_W     = 1;

    // Owner ids as stored in slot_owner
    typedef enum logic [DEF_OWN_W-1:0] {
        OWNER_PLAYER = 1'b0,
        OWNER_ENEMY  = 1'b1
    } owner_e;

endpackage

// File: rtl/lowest_free_finder.sv
// rtl/lowest_free_finder.sv - priority encoder returning the lowest-index free slot
//
// Ports:
//   busy  : occupancy vector, bit i high when slot i is taken
//   found : high when at least one slot is free
//   index : lowest index with busy==0 (0 when none found)
module lowest_free_finder
    import bullet_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SLOT_W    = DEF_SLOT_W
) (
    input  logic [NUM_SLOTS-1:0] busy,
    output logic                 found,
    output logic [SLOT_W-1:0]    index
);

    // Scan from the top down so the lowest free slot is the last write
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                index = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/bullet_slot_allocator.sv
// rtl/bullet_slot_allocator.sv - round-robin fire arbiter with per-requester cooldown and bullet slot pool
//
// Ports:
//   clock, resetn  : clock and asynchronous active-low reset
//   clear          : synchronous free-all / zero-all-cooldowns
//   req            : level fire request per requester
//   slot_release   : one-cycle pulse per slot, its bullet is gone
//   fire_bullet    : one-cycle launch pulse to the chosen slot
//   grant          : one-cycle pulse to the winning requester
//   grant_slot     : launched slot index, valid while grant != 0
//   slot_busy      : occupancy vector
//   slot_owner     : owner id per slot, slot i at [OWN_W*i +: OWN_W]
//   free_count     : number of free slots
//   pool_empty     : high when no slot is free
module bullet_slot_allocator
    import bullet_pkg::*;
#(
    parameter int          NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int          NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned COOLDOWN  = DEF_COOLDOWN,
    parameter int          SLOT_W    = DEF_SLOT_W,
    parameter int          OWN_W     = DEF_OWN_W
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_SLOTS-1:0]       slot_release,
    output logic [NUM_SLOTS-1:0]       fire_bullet,
    output logic [NUM_REQ-1:0]         grant,
    output logic [SLOT_W-1:0]          grant_slot,
    output logic [NUM_SLOTS-1:0]       slot_busy,
    output logic [NUM_SLOTS*OWN_W-1:0] slot_owner,
    output logic [SLOT_W:0]            free_count,
    output logic                       pool_empty
);

    // A requester is READY when its counter is zero and COOL otherwise
    logic [31:0]          cool_cnt [NUM_REQ];
    logic [OWN_W-1:0]     rr_ptr;

    logic                 free_found;
    logic [SLOT_W-1:0]    free_idx;

    logic [NUM_REQ-1:0]   eligible;
    logic                 win_valid;
    logic [OWN_W-1:0]     win_idx;
    logic [OWN_W-1:0]     ptr_next;
    int                   cand;

    logic                 do_alloc;
    logic [NUM_SLOTS-1:0] alloc_vec;
    logic [NUM_SLOTS-1:0] busy_next;
    logic [SLOT_W:0]      busy_cnt;
    logic [SLOT_W:0]      free_next;

    // Slot choice looks at registered occupancy only, so a slot released
    // this cycle is not reusable until the next one
    lowest_free_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_finder (
        .busy  (slot_busy),
        .found (free_found),
        .index (free_idx)
    );

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            eligible[r] = req[r] && (cool_cnt[r] == 32'd0);
        end
    end

    // Round-robin: first eligible requester at or after rr_ptr. Walking k
    // downwards lets the smallest offset overwrite the others.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = OWN_W'(cand);
            end
        end
    end

    always_comb begin
        if (win_idx == OWN_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = win_idx + OWN_W'(1);
        end
    end

    // Without a free slot nothing moves: no grant, no cooldown, no pointer step
    assign do_alloc  = win_valid && free_found;
    assign alloc_vec = do_alloc ? (NUM_SLOTS'(1) << free_idx) : '0;

    // Releases of free slots fall out naturally: clearing a zero bit is a no-op
    assign busy_next = (slot_busy & ~slot_release) | alloc_vec;

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy_cnt = busy_cnt + (SLOT_W+1)'(busy_next[i]);
        end
    end

    assign free_next = (SLOT_W+1)'(NUM_SLOTS) - busy_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fire_bullet <= '0;
            grant       <= '0;
            grant_slot  <= '0;
            slot_busy   <= '0;
            slot_owner  <= '0;
            free_count  <= (SLOT_W+1)'(NUM_SLOTS);
            pool_empty  <= 1'b0;
            rr_ptr      <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                cool_cnt[r] <= 32'd0;
            end
        end else if (clear) begin
            fire_bullet <= '0;
            grant       <= '0;
            grant_slot  <= '0;
            slot_busy   <= '0;
            slot_owner  <= '0;
            free_count  <= (SLOT_W+1)'(NUM_SLOTS);
            pool_empty  <= 1'b0;
            rr_ptr      <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                cool_cnt[r] <= 32'd0;
            end
        end else begin
            fire_bullet <= alloc_vec;
            grant       <= do_alloc ? (NUM_REQ'(1) << win_idx) : '0;
            slot_busy   <= busy_next;
            free_count  <= free_next;
            pool_empty  <= (free_next == '0);
            if (do_alloc) begin
                grant_slot <= free_idx;
                slot_owner[int'(free_idx)*OWN_W +: OWN_W] <= win_idx;
                rr_ptr <= ptr_next;
            end
            // Loading COOLDOWN-1 makes the grant-to-grant spacing exactly COOLDOWN
            for (int r = 0; r < NUM_REQ; r++) begin
                if (do_alloc && (win_idx == OWN_W'(r))) begin
                    cool_cnt[r] <= 32'(COOLDOWN - 1);
                end else if (cool_cnt[r] != 32'd0) begin
                    cool_cnt[r] <= cool_cnt[r] - 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/bullet_slot_allocator.md
Name: bullet_slot_allocator

Overview:
Scheduler for the shared bullet-instance pool. Accepts fire requests from several shooters (player ship, enemies), applies a per-requester cooldown, arbitrates round-robin, and issues a one-cycle launch pulse to the lowest-indexed free bullet slot. It tracks slot occupancy and ownership until the slot's collision/off-screen release pulse arrives. It sits between the input/AI logic and the array of bullet instances.

Parameters:
NUM_SLOTS, 30, number of bullet instances in the pool (1..32)
NUM_REQ, 2, number of requesters (1..4)
COOLDOWN, 5000000, minimum clock cycles between two grants to the same requester (>=1)
SLOT_W, 5, width of a slot index; must satisfy 2**SLOT_W >= NUM_SLOTS
OWN_W, 1, width of an owner id; must satisfy 2**OWN_W >= NUM_REQ

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous: free all slots and zero all cooldowns
req  input  NUM_REQ  level request per requester; bit r is high while requester r wants to fire
release  input  NUM_SLOTS  one-cycle pulse per slot; the slot's bullet collided or left the screen
fire_bullet  output  NUM_SLOTS  one-cycle launch pulse to the bullet instance
grant  output  NUM_REQ  one-cycle pulse to the requester whose shot launched
grant_slot  output  SLOT_W  index of the launched slot; valid while grant is nonzero
slot_busy  output  NUM_SLOTS  occupancy vector
slot_owner  output  NUM_SLOTS*OWN_W  owner id per slot (slot i at bits [OWN_W*i +: OWN_W]); valid while busy
free_count  output  SLOT_W+1  number of free slots
pool_empty  output  1  high when free_count==0

Behaviour:
- Reset values (async, resetn low): fire_bullet=0, grant=0, grant_slot=0, slot_busy=0, slot_owner=0, free_count=NUM_SLOTS, pool_empty=0. All cooldown counters=0. Round-robin pointer=0. All outputs are registered.
- Per-requester state machine with two states:
  - READY (cooldown counter==0): the requester is eligible when req[r]=1.
  - COOL: the counter decrements by 1 every cycle. The requester moves to READY the cycle after the counter reaches 0.
  - When requester r is granted, its counter loads COOLDOWN-1. With COOLDOWN=1 it is eligible again on the next cycle, so back-to-back grants are legal.
- Arbitration and issue:
  - At most one grant per cycle.
  - Winner: the first eligible requester at or after the round-robin pointer, modulo NUM_REQ. After a grant the pointer moves to winner+1.
  - Slot choice: lowest-index slot with slot_busy=0, evaluated on the current registered state.
  - Latency: with req sampled high at edge N, fire_bullet[s], grant[r] and grant_slot=s are high for exactly the cycle after edge N. slot_busy[s] and slot_owner[s]=r also update at edge N.
- No free slot (pool_empty):
  - No grant is issued.
  - Cooldown is not loaded.
  - The pointer does not move.
  - The request stays pending because req is a level.
- Release:
  - release[i] clears slot_busy[i] at the next edge.
  - A released slot cannot be allocated in the same cycle its release is sampled; it becomes allocatable one cycle later.
  - A release on an already free slot is ignored, and free_count does not change.
- free_count: NUM_SLOTS minus the popcount of slot_busy; updated in the same edge as slot_busy. Simultaneous allocate and release keep free_count unchanged.
- clear:
  - Takes priority over everything else.
  - Next edge: slot_busy=0, free_count=NUM_SLOTS, all counters=0, pointer=0, grant=0, fire_bullet=0.
  - clear does not pulse any release.
- resetn asserted mid-cooldown or with busy slots: everything returns to reset values immediately. No fire pulse is emitted.
- Width rules:
  - Cooldown counters are 32-bit unsigned.
  - Only slot indices below NUM_SLOTS are ever selected.
  - grant is one-hot or zero, and so is fire_bullet.

Decomposition:
- Shared package (bullet_pkg): NUM_SLOTS, SLOT_W, OWN_W, and the default COOLDOWN constant, plus the owner-id encoding (PLAYER=0, ENEMY=1).
- One natural sub-module, lowest_free_finder: combinational priority encoder over ~slot_busy that outputs a found flag and an index.
- The arbiter, cooldown counters and slot bookkeeping stay in the top module.

Test Plan:
Run the bench with COOLDOWN=4, NUM_SLOTS=4, NUM_REQ=2.
1. Reset, then hold req=01 -> grants at cycles 1, 5, 9, 13 with grant_slot=0, 1, 2, 3 and fire_bullet pulses 0001, 0010, 0100, 1000. After that pool_empty=1 and no further grants.
2. Pool full, pulse release=0100 for one cycle -> slot_busy=1011 next cycle. The next grant uses slot 2, no earlier than two cycles after the release pulse.
3. From reset, hold req=11 -> requester 0 granted at cycle 1 and requester 1 at cycle 2. Then alternating grants each time a requester finishes its cooldown, and slot_owner reads 0, 1, 0, 1 for slots 0..3.
4. Allocate and release in the same cycle: slots 0..2 busy, req=01 eligible, release=0001 -> grant_slot=3 (slot 0 not reused). free_count stays 1, then reads 1 after the grant.
5. Slots busy and requester mid-cooldown, then assert clear -> next cycle slot_busy=0, free_count=4. The requester is granted on the following cycle with grant_slot=0.
6. resetn dropped asynchronously between edges while fire_bullet is high -> fire_bullet, grant and slot_busy go to 0 immediately, with no clock edge needed.
